// File: rtl/vregfile_banked_bypass.sv
// Banked multi-lane vector register file: two registered read ports (a, b), one byte-masked
// write port (c), one independent bank per lane, write-first bypass, and a clear sequencer
// that zeroes every register after reset or on request.
module vregfile_banked_bypass #(
  parameter int unsigned NUMLANES    = 2,
  parameter int unsigned LANEWIDTH   = 128,
  parameter int unsigned NUMREGS     = 128,
  parameter int unsigned LOG2NUMREGS = 7
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clr_start,
  output logic                              busy,
  input  logic [NUMLANES*LOG2NUMREGS-1:0]   a_reg,
  input  logic [NUMLANES-1:0]               a_en,
  output logic [NUMLANES*LANEWIDTH-1:0]     a_readdataout,
  input  logic [NUMLANES*LOG2NUMREGS-1:0]   b_reg,
  input  logic [NUMLANES-1:0]               b_en,
  output logic [NUMLANES*LANEWIDTH-1:0]     b_readdataout,
  input  logic [NUMLANES*LOG2NUMREGS-1:0]   c_reg,
  input  logic [NUMLANES*LANEWIDTH-1:0]     c_writedatain,
  input  logic [NUMLANES*LANEWIDTH/8-1:0]   c_byteen,
  input  logic [NUMLANES-1:0]               c_we
);

  localparam int unsigned NumBytes = LANEWIDTH / 8;
  localparam logic [LOG2NUMREGS-1:0] LastAddr = LOG2NUMREGS'(NUMREGS - 1);

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StRun   = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [LOG2NUMREGS-1:0] cnt_q, cnt_d;
  logic                   run;

  assign run  = (state_q == StRun);
  assign busy = (state_q == StClear);

  // Clear sequencer next state: sweep every address once, then hand over to RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StClear) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LastAddr) begin
        state_d = StRun;
      end
    end else if (clr_start) begin
      state_d = StClear;
      cnt_d   = '0;
    end
  end

  // Sequencer state; reset always restarts the clear pass from address 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar k = 0; k < NUMLANES; k++) begin : g_lane
    logic [LANEWIDTH-1:0]   mem_q [NUMREGS];
    logic [LOG2NUMREGS-1:0] a_addr, b_addr, c_addr;
    logic [NumBytes-1:0]    be;
    logic [LANEWIDTH-1:0]   wdata;
    logic [LANEWIDTH-1:0]   a_rd, b_rd;
    logic [LANEWIDTH-1:0]   a_q, b_q;
    logic                   wr;

    assign a_addr = a_reg[k*LOG2NUMREGS +: LOG2NUMREGS];
    assign b_addr = b_reg[k*LOG2NUMREGS +: LOG2NUMREGS];
    assign c_addr = c_reg[k*LOG2NUMREGS +: LOG2NUMREGS];
    assign be     = c_byteen[k*NumBytes +: NumBytes];
    assign wdata  = c_writedatain[k*LANEWIDTH +: LANEWIDTH];
    assign wr     = run && c_we[k];

    // Read data with write-first bypass: enabled bytes of a same-address write override.
    always_comb begin
      a_rd = mem_q[a_addr];
      b_rd = mem_q[b_addr];
      if (wr && (c_addr == a_addr)) begin
        for (int j = 0; j < NumBytes; j++) begin
          if (be[j]) a_rd[8*j +: 8] = wdata[8*j +: 8];
        end
      end
      if (wr && (c_addr == b_addr)) begin
        for (int j = 0; j < NumBytes; j++) begin
          if (be[j]) b_rd[8*j +: 8] = wdata[8*j +: 8];
        end
      end
    end

    // Storage update: zero sweep while clearing, byte-masked write while running.
    always_ff @(posedge clk) begin
      if (!run && !reset) begin
        mem_q[cnt_q] <= '0;
      end else if (wr && !reset) begin
        for (int j = 0; j < NumBytes; j++) begin
          if (be[j]) mem_q[c_addr][8*j +: 8] <= wdata[8*j +: 8];
        end
      end
    end

    // Registered read outputs; a disabled lane holds, a clear-time read returns zero.
    always_ff @(posedge clk) begin
      if (reset) begin
        a_q <= '0;
        b_q <= '0;
      end else begin
        if (a_en[k]) a_q <= run ? a_rd : '0;
        if (b_en[k]) b_q <= run ? b_rd : '0;
      end
    end

    assign a_readdataout[k*LANEWIDTH +: LANEWIDTH] = a_q;
    assign b_readdataout[k*LANEWIDTH +: LANEWIDTH] = b_q;
  end

endmodule

// File: tb/tb_vregfile_banked_bypass.sv
// Directed testbench for vregfile_banked_bypass with the default 2 x 128-bit x 128 geometry.
module tb_vregfile_banked_bypass;

  localparam int NL = 2;
  localparam int LW = 128;
  localparam int NR = 128;
  localparam int AW = 7;
  localparam int NB = LW / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              clr_start;
  logic              busy;
  logic [NL*AW-1:0]  a_reg, b_reg, c_reg;
  logic [NL-1:0]     a_en, b_en, c_we;
  logic [NL*LW-1:0]  a_readdataout, b_readdataout, c_writedatain;
  logic [NL*NB-1:0]  c_byteen;

  int n_checks = 0;
  int n_fail   = 0;

  vregfile_banked_bypass #(
    .NUMLANES(NL), .LANEWIDTH(LW), .NUMREGS(NR), .LOG2NUMREGS(AW)
  ) dut (
    .clk(clk), .reset(reset), .clr_start(clr_start), .busy(busy),
    .a_reg(a_reg), .a_en(a_en), .a_readdataout(a_readdataout),
    .b_reg(b_reg), .b_en(b_en), .b_readdataout(b_readdataout),
    .c_reg(c_reg), .c_writedatain(c_writedatain), .c_byteen(c_byteen), .c_we(c_we)
  );

  always #5 clk = ~clk;

  localparam logic [LW-1:0] PatA5  = {16{8'hA5}};
  localparam logic [LW-1:0] Pat3C  = {16{8'h3C}};
  localparam logic [LW-1:0] PatMix = 128'hA5A5A5A5_A5A5A5A5_3C3C3C3C_A5A5A5A5;
  localparam logic [LW-1:0] Pat11  = {16{8'h11}};
  localparam logic [LW-1:0] Pat77  = {16{8'h77}};
  localparam logic [LW-1:0] Pat88  = {16{8'h88}};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr_start = 1'b0;
    a_reg = '0; b_reg = '0; c_reg = '0;
    a_en = '0; b_en = '0; c_we = '0;
    c_writedatain = '0; c_byteen = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 1", busy);
    end
    n_checks++;
    if (a_readdataout !== '0 || b_readdataout !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got a=%h b=%h expected 0", a_readdataout, b_readdataout);
    end
  endtask

  task automatic test_initial_clear();
    int n = 0;
    reset = 1'b0;
    while (busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != NR) begin
      n_fail++; $display("FAIL init_clear_len: got %0d cycles expected %0d", n, NR);
    end
    a_reg[1*AW +: AW] = 7'd127;
    a_en = 2'b10;
    tick();
    a_en = '0;
    n_checks++;
    if (a_readdataout[LW +: LW] !== '0) begin
      n_fail++; $display("FAIL init_read127: got %h expected 0", a_readdataout[LW +: LW]);
    end
  endtask

  task automatic test_write_read();
    c_we = 2'b01;
    c_reg[0 +: AW] = 7'd3;
    c_writedatain[0 +: LW] = PatA5;
    c_byteen[0 +: NB] = '1;
    tick();
    c_we = '0;
    a_reg[0 +: AW] = 7'd3;
    a_reg[AW +: AW] = 7'd3;
    a_en = 2'b11;
    tick();
    a_en = '0;
    n_checks++;
    if (a_readdataout[0 +: LW] !== PatA5) begin
      n_fail++; $display("FAIL wr_lane0: got %h expected %h", a_readdataout[0 +: LW], PatA5);
    end
    n_checks++;
    if (a_readdataout[LW +: LW] !== '0) begin
      n_fail++; $display("FAIL wr_lane1_isolated: got %h expected 0", a_readdataout[LW +: LW]);
    end
  endtask

  task automatic test_partial_byteen();
    c_we = 2'b01;
    c_reg[0 +: AW] = 7'd3;
    c_writedatain[0 +: LW] = Pat3C;
    c_byteen[0 +: NB] = 16'h00F0;
    tick();
    c_we = '0;
    b_reg[0 +: AW] = 7'd3;
    b_en = 2'b01;
    tick();
    b_en = '0;
    n_checks++;
    if (b_readdataout[0 +: LW] !== PatMix) begin
      n_fail++; $display("FAIL partial_byteen: got %h expected %h", b_readdataout[0 +: LW], PatMix);
    end
  endtask

  task automatic test_bypass();
    logic [LW-1:0] exp;
    c_we = 2'b10;
    c_reg[AW +: AW] = 7'd9;
    c_writedatain[LW +: LW] = 128'h1234;
    c_byteen[NB +: NB] = '1;
    a_reg[AW +: AW] = 7'd9;
    a_en = 2'b10;
    tick();
    a_en = '0;
    n_checks++;
    if (a_readdataout[LW +: LW] !== 128'h1234) begin
      n_fail++; $display("FAIL bypass_full: got %h expected 1234", a_readdataout[LW +: LW]);
    end
    n_checks++;
    if (a_readdataout[0 +: LW] !== PatA5) begin
      n_fail++; $display("FAIL bypass_lane0_hold: got %h expected %h", a_readdataout[0 +: LW], PatA5);
    end
    // Only byte 1 written; byte 0 must come from the stored 0x34.
    c_writedatain[LW +: LW] = {16{8'hFF}};
    c_byteen[NB +: NB] = 16'h0002;
    b_reg[AW +: AW] = 7'd9;
    b_en = 2'b10;
    tick();
    c_we = '0;
    b_en = '0;
    exp = 128'hFF34;
    n_checks++;
    if (b_readdataout[LW +: LW] !== exp) begin
      n_fail++; $display("FAIL bypass_partial: got %h expected %h", b_readdataout[LW +: LW], exp);
    end
  endtask

  task automatic test_both_ports();
    a_reg[0 +: AW] = 7'd3;
    b_reg[0 +: AW] = 7'd3;
    a_en = 2'b01;
    b_en = 2'b01;
    tick();
    a_en = '0;
    b_en = '0;
    n_checks++;
    if (a_readdataout[0 +: LW] !== PatMix || b_readdataout[0 +: LW] !== PatMix) begin
      n_fail++; $display("FAIL both_ports: got a=%h b=%h expected %h",
                         a_readdataout[0 +: LW], b_readdataout[0 +: LW], PatMix);
    end
  endtask

  task automatic test_hold();
    c_we = 2'b01;
    c_reg[0 +: AW] = 7'd3;
    c_writedatain[0 +: LW] = Pat11;
    c_byteen[0 +: NB] = '1;
    a_reg[0 +: AW] = 7'd3;
    tick();
    c_we = '0;
    n_checks++;
    if (a_readdataout[0 +: LW] !== PatMix) begin
      n_fail++; $display("FAIL hold: got %h expected %h", a_readdataout[0 +: LW], PatMix);
    end
    a_en = 2'b01;
    tick();
    a_en = '0;
    n_checks++;
    if (a_readdataout[0 +: LW] !== Pat11) begin
      n_fail++; $display("FAIL after_hold_read: got %h expected %h", a_readdataout[0 +: LW], Pat11);
    end
  endtask

  task automatic test_clear_request();
    int n = 0;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL clr_busy_rise: got %b expected 1", busy);
    end
    // Writes during the pass must be dropped; reads during the pass return zero.
    c_we = 2'b01;
    c_reg[0 +: AW] = 7'd3;
    c_writedatain[0 +: LW] = {16{8'hFF}};
    c_byteen[0 +: NB] = '1;
    a_reg[0 +: AW] = 7'd3;
    a_en = 2'b01;
    while (busy === 1'b1 && n < 300) begin
      clr_start = (n == 10);
      tick();
      n++;
    end
    clr_start = 1'b0;
    c_we = '0;
    a_en = '0;
    n_checks++;
    if (n != NR) begin
      n_fail++; $display("FAIL clr_len: got %0d cycles expected %0d", n, NR);
    end
    n_checks++;
    if (a_readdataout[0 +: LW] !== '0) begin
      n_fail++; $display("FAIL clr_read_during: got %h expected 0", a_readdataout[0 +: LW]);
    end
    b_reg[0 +: AW] = 7'd3;
    b_reg[AW +: AW] = 7'd9;
    b_en = 2'b11;
    tick();
    b_en = '0;
    n_checks++;
    if (b_readdataout !== '0) begin
      n_fail++; $display("FAIL clr_regs_zero: got %h expected 0", b_readdataout);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    c_we = 2'b11;
    c_reg[0 +: AW] = 7'd5;
    c_reg[AW +: AW] = 7'd100;
    c_writedatain = {Pat88, Pat77};
    c_byteen = '1;
    tick();
    c_we = '0;
    a_reg[0 +: AW] = 7'd5;
    b_reg[AW +: AW] = 7'd100;
    a_en = 2'b01;
    b_en = 2'b10;
    tick();
    a_en = '0;
    b_en = '0;
    n_checks++;
    if (a_readdataout[0 +: LW] !== Pat77 || b_readdataout[LW +: LW] !== Pat88) begin
      n_fail++; $display("FAIL pre_clear_read: got a=%h b=%h", a_readdataout[0 +: LW],
                         b_readdataout[LW +: LW]);
    end
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (50) tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b1 || a_readdataout !== '0 || b_readdataout !== '0) begin
      n_fail++; $display("FAIL mid_reset_state: got busy=%b a=%h b=%h expected 1/0/0",
                         busy, a_readdataout, b_readdataout);
    end
    reset = 1'b0;
    while (busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != NR) begin
      n_fail++; $display("FAIL mid_reset_len: got %0d cycles expected %0d", n, NR);
    end
    // Load a nonzero value into the outputs so the following zero reads are observable.
    c_we = 2'b11;
    c_reg[0 +: AW] = 7'd6;
    c_reg[AW +: AW] = 7'd6;
    c_writedatain = {Pat11, Pat3C};
    tick();
    c_we = '0;
    a_reg[0 +: AW] = 7'd6;
    a_reg[AW +: AW] = 7'd6;
    a_en = 2'b11;
    tick();
    n_checks++;
    if (a_readdataout !== {Pat11, Pat3C}) begin
      n_fail++; $display("FAIL post_reset_write: got %h expected %h", a_readdataout, {Pat11, Pat3C});
    end
    a_reg[0 +: AW] = 7'd5;
    a_reg[AW +: AW] = 7'd100;
    tick();
    a_en = '0;
    n_checks++;
    if (a_readdataout !== '0) begin
      n_fail++; $display("FAIL mid_reset_cleared: got %h expected 0", a_readdataout);
    end
  endtask

  initial begin
    test_reset();
    test_initial_clear();
    test_write_read();
    test_partial_byteen();
    test_bypass();
    test_both_ports();
    test_hold();
    test_clear_request();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vregfile_banked_bypass.md
Name: vregfile_banked_bypass

Overview:
Parametrised multi-lane vector register file: two read ports (a, b), one write port (c), one independent bank per lane. Generalises the fixed 2-lane/128-bit/128-entry vector register file with true per-byte write enables, per-lane read enables and write-to-read bypass. Adds a built-in clear sequencer that zeroes every register after reset or on request. Sits in the vector lane datapath between the issue stage and the vector ALUs / memory unit.

Parameters:
NUMLANES, 2, number of lanes (banks)
LANEWIDTH, 128, data bits per lane; multiple of 8
NUMREGS, 128, registers per lane
LOG2NUMREGS, 7, address bits; equals ceil(log2(NUMREGS))

Ports:
clk  input  1  clock, all logic rising-edge
reset  input  1  synchronous, active-high reset
clr_start  input  1  pulse: start a clear pass (ignored while busy)
busy  output  1  high while the clear sequencer runs
a_reg  input  NUMLANES*LOG2NUMREGS  port-a address, lane k at [k*LOG2NUMREGS +: LOG2NUMREGS]
a_en  input  NUMLANES  port-a per-lane read enable
a_readdataout  output  NUMLANES*LANEWIDTH  port-a data, lane k at [k*LANEWIDTH +: LANEWIDTH]
b_reg  input  NUMLANES*LOG2NUMREGS  port-b address
b_en  input  NUMLANES  port-b per-lane read enable
b_readdataout  output  NUMLANES*LANEWIDTH  port-b data
c_reg  input  NUMLANES*LOG2NUMREGS  write address
c_writedatain  input  NUMLANES*LANEWIDTH  write data
c_byteen  input  NUMLANES*LANEWIDTH/8  byte enables, lane k byte j at bit k*(LANEWIDTH/8)+j, covering data bits [8j +: 8]
c_we  input  NUMLANES  per-lane write enable

Behaviour:
- Reset (reset=1 at edge): a_readdataout=0, b_readdataout=0, busy=1, clear counter=0. Storage contents are not reset directly; the clear pass zeroes them.
- FSM states: CLEAR, RUN.
- Reset forces CLEAR. RUN->CLEAR on clr_start=1. clr_start in CLEAR is ignored.
- CLEAR: each cycle, write zero to address=counter in every lane, all bytes. Counter increments by 1.
- CLEAR exits to RUN on the edge that writes address NUMREGS-1. busy falls on that same edge.
- Clear pass duration: busy high for exactly NUMREGS cycles after reset release or after the clr_start edge.
- In CLEAR: c_we is ignored. A read with en=1 returns 0 on the next edge; a read with en=0 holds the output.
- Reset during CLEAR restarts the pass at counter 0.
- RUN write: if c_we[k]=1, lane k byte j of register c_reg[k] takes c_writedatain byte j where c_byteen bit is 1. Bytes with byteen=0 are unchanged. c_we[k]=1 with all byteen 0 changes nothing.
- RUN read, 1-cycle latency, registered output:
  - en[k]=1 at edge N: lane k output shows register contents as of edge N, valid after edge N.
  - en[k]=0: lane k output holds its previous value.
- Bypass (write-first): a read in the same cycle as a write to the same lane and address returns the merged data. Enabled bytes come from c_writedatain; other bytes keep the old value. Applies to ports a and b independently.
- Lanes are fully independent. No cross-lane address or data interaction.
- Both read ports may address the same register simultaneously; both return identical data.

Test Plan:
- Release reset -> busy=1 for exactly 128 cycles, then 0. Then read reg 127 lane 1 on port a -> 0 on the next cycle.
- RUN: write lane 0 reg 3 = {16{8'hA5}}, all byteen=1. Next cycle a_reg=3, a_en=1 -> lane 0 output {16{8'hA5}}; lane 1 output unaffected.
- Partial byteen: write lane 0 reg 3 with data {16{8'h3C}}, byteen=16'h00F0. Read via port b -> bytes 4..7 = 3C, all other bytes = A5.
- Bypass: same cycle, write lane 1 reg 9 = 128'h1234 (all bytes enabled) and read port a lane 1 reg 9 -> a_readdataout lane 1 = 128'h1234 after that edge.
- Hold / ignore: drop a_en -> output holds through a later write to the same register. clr_start, then c_we to reg 3 during busy -> ignored; a read after busy falls -> reg 3 = 0.
- Reset at counter=50 of a clear pass -> busy stays high another 128 cycles, and all registers read 0 afterwards.
